bsg_mem_1rw_sync_mask_write_byte_rv_master: RTL and testbench

- Initiator-side controller that drives one single-port, synchronous, byte-masked-write memory (1RW, 1-cycle read latency, no-change read/write modes).
- Command side: valid/ready requests (read or byte-masked write).
- Read data returns in issue order through a 3-entry valid/yumi response buffer.
- Optional post-reset zero-fill sweep, so client logic never sees uninitialised RAM.

---
 rtl/bsg_mem_1rw_sync_mask_write_byte_rv_master.sv | 118 +++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_byte_rv_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_rv_master.sv
// Initiator for a 1RW sync byte-masked RAM: optional zero-fill sweep, then in-order command issue.
// Reads return 2 cycles after issue via a 3-entry buffer; ready_o drops when buffered + in-flight reads reach 3.
module bsg_mem_1rw_sync_mask_write_byte_rv_master
  #(parameter int els_p = 8
   ,parameter int data_width_p = 32
   ,parameter bit init_zero_p = 1'b1
   ,localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
   ,localparam int write_mask_width_lp = data_width_p >> 3
   )
  (input  logic                           clk_i
  ,input  logic                           reset_i
  ,input  logic                           v_i
  ,input  logic                           w_i
  ,input  logic [addr_width_lp-1:0]       addr_i
  ,input  logic [data_width_p-1:0]        data_i
  ,input  logic [write_mask_width_lp-1:0] write_mask_i
  ,output logic                           ready_o
  ,output logic [data_width_p-1:0]        data_o
  ,output logic                           v_o
  ,input  logic                           yumi_i
  ,output logic                           init_done_o
  ,output logic                           mem_v_o
  ,output logic                           mem_w_o
  ,output logic [addr_width_lp-1:0]       mem_addr_o
  ,output logic [data_width_p-1:0]        mem_data_o
  ,output logic [write_mask_width_lp-1:0] mem_w_mask_o
  ,input  logic [data_width_p-1:0]        mem_data_i
  );

  typedef enum logic {eINIT, eREADY} state_e;

  state_e                   r_state, w_state_next;
  logic [addr_width_lp-1:0] r_init_cnt, w_init_cnt_next;
  logic                     r_rd_inflight;
  logic [1:0]               r_cnt, w_cnt_next, w_wr_idx;
  logic [data_width_p-1:0]  r_buf [3];
  logic [data_width_p-1:0]  w_buf_next [3];
  logic                     w_accept, w_issue_rd, w_push, w_pop;
  logic [2:0]               w_occupancy;

  // Occupancy counts the read already in flight so its landing slot is always free.
  assign w_occupancy = {1'b0, r_cnt} + {2'b00, r_rd_inflight};
  assign ready_o     = ~reset_i & (r_state == eREADY) & (w_occupancy < 3'd3);
  assign w_accept    = v_i & ready_o;
  assign w_issue_rd  = w_accept & ~w_i;
  assign w_push      = r_rd_inflight;
  assign w_pop       = yumi_i & (r_cnt != 2'd0);
  assign w_wr_idx    = r_cnt - {1'b0, w_pop};

  assign v_o         = ~reset_i & (r_cnt != 2'd0);
  assign data_o      = reset_i ? '0 : r_buf[0];
  assign init_done_o = (r_state == eREADY) & ~(reset_i & init_zero_p);

  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    mem_v_o         = 1'b0;
    mem_w_o         = 1'b0;
    mem_addr_o      = '0;
    mem_data_o      = '0;
    mem_w_mask_o    = '0;
    case (r_state)
      eINIT: begin
        mem_v_o         = ~reset_i;
        mem_w_o         = 1'b1;
        mem_addr_o      = r_init_cnt;
        mem_w_mask_o    = '1;
        w_init_cnt_next = r_init_cnt + addr_width_lp'(1);
        if (r_init_cnt == addr_width_lp'(els_p - 1))
          w_state_next = eREADY;
      end
      eREADY: begin
        if (w_accept) begin
          mem_v_o      = 1'b1;
          mem_w_o      = w_i;
          mem_addr_o   = addr_i;
          mem_data_o   = data_i;
          mem_w_mask_o = w_i ? write_mask_i : '0;
        end
      end
      default: w_state_next = eINIT;
    endcase
  end

  // Head stays in slot 0; the last entry is not shifted out so data_o holds once empty.
  always_comb begin
    for (int i = 0; i < 3; i++)
      w_buf_next[i] = r_buf[i];
    if (w_pop && (r_cnt > 2'd1)) begin
      w_buf_next[0] = r_buf[1];
      w_buf_next[1] = r_buf[2];
    end
    if (w_push && (w_wr_idx != 2'd3))
      w_buf_next[w_wr_idx] = mem_data_i;
    w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= init_zero_p ? eINIT : eREADY;
      r_init_cnt    <= '0;
      r_rd_inflight <= 1'b0;
      r_cnt         <= 2'd0;
      for (int i = 0; i < 3; i++)
        r_buf[i] <= '0;
    end else begin
      r_state       <= w_state_next;
      r_init_cnt    <= w_init_cnt_next;
      r_rd_inflight <= w_issue_rd;
      r_cnt         <= w_cnt_next;
      for (int i = 0; i < 3; i++)
        r_buf[i] <= w_buf_next[i];
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_rv_master.sv
// Directed bench: sweep, masked writes, backpressure, throughput, zero-mask write, mid-run reset.
module tb_bsg_mem_1rw_sync_mask_write_byte_rv_master;
    localparam int ELS = 8;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam int AW  = 3;

    logic          clk_i = 1'b0;
    logic          reset_i, v_i, w_i, yumi_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i;
    logic [MW-1:0] write_mask_i;
    logic          ready_o, v_o, init_done_o;
    logic [DW-1:0] data_o;
    logic          mem_v_o, mem_w_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o, mem_data_i;
    logic [MW-1:0] mem_w_mask_o;

    always #5 clk_i = ~clk_i;

    bsg_mem_1rw_sync_mask_write_byte_rv_master #(
        .els_p(ELS), .data_width_p(DW), .init_zero_p(1'b1)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
        .data_i(data_i), .write_mask_i(write_mask_i), .ready_o(ready_o), .data_o(data_o),
        .v_o(v_o), .yumi_i(yumi_i), .init_done_o(init_done_o), .mem_v_o(mem_v_o),
        .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
    );

    // Byte-masked synchronous RAM, no-change on write; preload shows whether the sweep ran.
    logic          ram_preload;
    logic [DW-1:0] ram [ELS];
    always @(posedge clk_i) begin
        if (ram_preload) begin
            for (int i = 0; i < ELS; i++) ram[i] <= 32'hDEADBE00 | 32'(i);
        end else if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < MW; b++)
                    if (mem_w_mask_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
            end else begin
                mem_data_i <= ram[mem_addr_o];
            end
        end
    end

    // Contents after the preload writes; address 5 only ever sees a zero-mask write.
    logic [DW-1:0] exp_rd [ELS] = '{32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3,
                                    32'h000000A4, 32'h00000000, 32'h000000A6, 32'h000000A7};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
        v_i = v; w_i = w; addr_i = a; data_i = d; write_mask_i = m;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    int idx;

    initial begin
        reset_i = 1'b1; yumi_i = 1'b0; ram_preload = 1'b1;
        idle();
        cycle();
        ram_preload = 1'b0;
        #4;
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_v_o", 32'(v_o), 32'd0);
        check("rst_init_done", 32'(init_done_o), 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("rst_mem_v", 32'(mem_v_o), 32'd0);
        cycle();

        // Sweep: reads offered during it must be ignored.
        reset_i = 1'b0;
        for (int k = 0; k < ELS; k++) begin
            drive(1'b1, 1'b0, AW'(k), '0, '0);
            #4;
            check("sweep_mem_v", 32'(mem_v_o), 32'd1);
            check("sweep_mem_w", 32'(mem_w_o), 32'd1);
            check("sweep_addr", 32'(mem_addr_o), 32'(k));
            check("sweep_data", mem_data_o, 32'd0);
            check("sweep_mask", 32'(mem_w_mask_o), 32'hF);
            check("sweep_ready", 32'(ready_o), 32'd0);
            check("sweep_init_done", 32'(init_done_o), 32'd0);
            cycle();
        end

        // Masked write pair then read of address 3.
        drive(1'b1, 1'b1, 3'd3, 32'hAABBCCDD, 4'b1111);
        #4;
        check("c8_ready", 32'(ready_o), 32'd1);
        check("c8_init_done", 32'(init_done_o), 32'd1);
        check("wr1_mem_v", 32'(mem_v_o), 32'd1);
        check("wr1_mem_w", 32'(mem_w_o), 32'd1);
        check("wr1_addr", 32'(mem_addr_o), 32'd3);
        check("wr1_mask", 32'(mem_w_mask_o), 32'hF);
        cycle();
        drive(1'b1, 1'b1, 3'd3, 32'h11223344, 4'b0101);
        #4;
        check("wr2_mask", 32'(mem_w_mask_o), 32'h5);
        check("wr2_data", mem_data_o, 32'h11223344);
        cycle();
        drive(1'b1, 1'b0, 3'd3, 32'hFFFFFFFF, 4'b1111);
        #4;
        check("rd_mem_v", 32'(mem_v_o), 32'd1);
        check("rd_mem_w", 32'(mem_w_o), 32'd0);
        check("rd_mask_zero", 32'(mem_w_mask_o), 32'd0);
        check("no_resp_from_sweep", 32'(v_o), 32'd0);
        cycle();
        idle();
        #4;
        check("rd_lat1_v_o", 32'(v_o), 32'd0);
        cycle();
        yumi_i = 1'b1;
        #4;
        check("rd_lat2_v_o", 32'(v_o), 32'd1);
        check("rd_merged_data", data_o, 32'hAA22CC44);
        cycle();
        yumi_i = 1'b0;

        // Zero-mask write to 5: issued, no response, contents unchanged.
        drive(1'b1, 1'b1, 3'd5, 32'hFFFFFFFF, 4'b0000);
        #4;
        check("empty_v_o", 32'(v_o), 32'd0);
        check("empty_data_hold", data_o, 32'hAA22CC44);
        check("zm_mem_v", 32'(mem_v_o), 32'd1);
        check("zm_mask", 32'(mem_w_mask_o), 32'd0);
        cycle();
        drive(1'b1, 1'b0, 3'd5, '0, '0);
        #4;
        check("zm_no_resp_a", 32'(v_o), 32'd0);
        cycle();
        idle();
        #4;
        check("zm_no_resp_b", 32'(v_o), 32'd0);
        cycle();
        yumi_i = 1'b1;
        #4;
        check("zm_rd_v_o", 32'(v_o), 32'd1);
        check("zm_rd_data", data_o, 32'd0);
        cycle();
        yumi_i = 1'b0;

        // Preload distinct values.
        for (int i = 0; i < ELS; i++) begin
            if (i != 5) begin
                drive(1'b1, 1'b1, AW'(i), exp_rd[i], 4'hF);
                cycle();
            end
        end
        idle();

        // Backpressure: three reads fit, the fourth is held off.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, AW'(i), '0, '0);
            #4;
            check("bp_ready", 32'(ready_o), 32'd1);
            cycle();
        end
        drive(1'b1, 1'b0, 3'd3, '0, '0);
        #4;
        check("bp_ready_full", 32'(ready_o), 32'd0);
        check("bp_no_issue", 32'(mem_v_o), 32'd0);
        cycle();
        idle();
        #4;
        check("bp_v_o", 32'(v_o), 32'd1);
        check("bp_still_full", 32'(ready_o), 32'd0);
        check("bp_resp0", data_o, 32'hA0);
        yumi_i = 1'b1;
        cycle();
        #4;
        check("bp_ready_back", 32'(ready_o), 32'd1);
        check("bp_resp1", data_o, 32'hA1);
        cycle();
        #4;
        check("bp_resp2", data_o, 32'hA2);
        cycle();
        yumi_i = 1'b0;
        #4;
        check("bp_drained", 32'(v_o), 32'd0);
        cycle();

        // Full throughput: 16 reads, yumi follows v_o.
        idx = 0;
        for (int c = 0; c < 18; c++) begin
            yumi_i = 1'b0;
            if (c < 16) drive(1'b1, 1'b0, AW'(c % ELS), '0, '0);
            else idle();
            #4;
            if (c < 16) check("tp_ready", 32'(ready_o), 32'd1);
            check("tp_v_o", 32'(v_o), (c >= 2) ? 32'd1 : 32'd0);
            if (v_o) begin
                check("tp_data", data_o, exp_rd[idx % ELS]);
                idx++;
                yumi_i = 1'b1;
            end
            cycle();
        end
        yumi_i = 1'b0;
        check("tp_count", 32'(idx), 32'd16);

        // Reset with two responses buffered and one read in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, AW'(i), '0, '0);
            cycle();
        end
        idle();
        reset_i = 1'b1;
        #4;
        check("mr_rst_v_o", 32'(v_o), 32'd0);
        check("mr_rst_ready", 32'(ready_o), 32'd0);
        check("mr_rst_data", data_o, 32'd0);
        check("mr_rst_init_done", 32'(init_done_o), 32'd0);
        cycle();
        reset_i = 1'b0;
        for (int k = 0; k < ELS; k++) begin
            #4;
            check("mr_sweep_v_o", 32'(v_o), 32'd0);
            check("mr_sweep_mem_v", 32'(mem_v_o), 32'd1);
            check("mr_sweep_addr", 32'(mem_addr_o), 32'(k));
            cycle();
        end
        #4;
        check("mr_init_done", 32'(init_done_o), 32'd1);
        check("mr_no_stale", 32'(v_o), 32'd0);
        cycle();
        drive(1'b1, 1'b0, 3'd2, '0, '0);
        cycle();
        idle();
        #4;
        check("mr_rd_lat1", 32'(v_o), 32'd0);
        cycle();
        yumi_i = 1'b1;
        #4;
        check("mr_rd_v_o", 32'(v_o), 32'd1);
        check("mr_rd_zeroed", data_o, 32'd0);
        cycle();
        yumi_i = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
